// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK flip-flop excitation driver.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic MODE_SETRST = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation: which inputs move each flip-flop from q to target.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);
    import jk_drv_pkg::*;

    always_comb begin
        if (mode == MODE_TOGGLE) begin
            j = target ^ q;
            k = target ^ q;
        end else begin
            j = target & ~q;
            k = ~target & q;
        end
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Controller for a bank of JK flip-flops: drive one cycle, settle, verify Q, retry on mismatch.
module jk_excite_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 3,
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic             req_mode,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RW-1:0]    retry_cnt
);
    import jk_drv_pkg::*;

    localparam int CW = $clog2(SETTLE + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic             mode, mode_nxt;
    logic [CW-1:0]    settle, settle_nxt;
    logic [RW-1:0]    retry_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic             done_nxt, err_nxt;
    logic [WIDTH-1:0] exc_target, exc_j, exc_k;
    logic             exc_mode;

    // Accept loads from the live request; retries reload from the captured one.
    assign exc_target = (state == IDLE) ? req_target : target;
    assign exc_mode   = (state == IDLE) ? req_mode   : mode;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .target (exc_target),
        .q      (q_fb),
        .mode   (exc_mode),
        .j      (exc_j),
        .k      (exc_k)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        mode_nxt   = mode;
        settle_nxt = settle;
        retry_nxt  = retry_cnt;
        j_nxt      = '0;
        k_nxt      = '0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    target_nxt = req_target;
                    mode_nxt   = req_mode;
                    retry_nxt  = '0;
                    j_nxt      = exc_j;
                    k_nxt      = exc_k;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                settle_nxt = CW'(SETTLE);
                state_nxt  = WAIT;
            end
            WAIT: begin
                settle_nxt = settle - 1'b1;
                if (settle == CW'(1)) state_nxt = CHECK;
            end
            CHECK: begin
                if (q_fb == target) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (retry_cnt < RW'(MAX_RETRY)) begin
                    retry_nxt = retry_cnt + 1'b1;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    state_nxt = DRIVE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target    <= '0;
            mode      <= MODE_SETRST;
            settle    <= '0;
            retry_cnt <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            target    <= target_nxt;
            mode      <= mode_nxt;
            settle    <= settle_nxt;
            retry_cnt <= retry_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: drives a 4-bit JK flip-flop model from j/k and feeds Q back.
module tb_jk_excite_driver;

    localparam int WIDTH     = 4;
    localparam int SETTLE    = 1;
    localparam int MAX_RETRY = 3;
    localparam int PER       = SETTLE + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_target = '0;
    logic             req_mode = 1'b0;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j, k;
    logic             busy, done, err;
    logic [1:0]       retry_cnt;

    logic [WIDTH-1:0] q_bank = '0;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
    logic [WIDTH-1:0] q_model = '0;

    int checks = 0;
    int errors = 0;

    jk_excite_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_mode   (req_mode),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    // Ideal JK flip-flops; feedback can be overridden to emulate stuck bits.
    always @(posedge clk) q_bank <= (j & ~q_bank) | (~k & q_bank);
    assign q_fb = force_en ? force_val : q_bank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_excite(input logic [3:0] t, input logic [3:0] q, input logic m,
                                       output logic [3:0] ej, output logic [3:0] ek);
        ej = '0;
        ek = '0;
        for (int b = 0; b < 4; b++) begin
            if (t[b] != q[b]) begin
                if (m) begin
                    ej[b] = 1'b1;
                    ek[b] = 1'b1;
                end else if (t[b]) begin
                    ej[b] = 1'b1;
                end else begin
                    ek[b] = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_j"}, j, 0);
        chk({tag, "_k"}, k, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_retry"}, retry_cnt, 0);
    endtask

    // Called right after the accept edge; returns at the negedge of the done/err cycle.
    task automatic follow(input logic [3:0] ej, input logic [3:0] ek, input int attempts,
                          input logic eerr, input logic drop);
        int n_end;
        n_end = attempts * PER;
        for (int n = 0; n <= n_end; n++) begin
            if (n > 0) @(posedge clk);
            @(negedge clk);
            if (n == 0 && drop) req_valid = 1'b0;
            if (n < n_end) begin
                chk("busy", busy, 1);
                chk("ready_busy", req_ready, 0);
                chk("done_early", done, 0);
                chk("err_early", err, 0);
                chk("j_phase", j, (n % PER == 0) ? ej : 4'b0000);
                chk("k_phase", k, (n % PER == 0) ? ek : 4'b0000);
            end else begin
                chk("busy_end", busy, 0);
                chk("ready_end", req_ready, 1);
                chk("done_end", done, !eerr);
                chk("err_end", err, eerr);
                chk("retry_end", retry_cnt, attempts - 1);
                chk("j_end", j, 0);
                chk("k_end", k, 0);
            end
        end
    endtask

    task automatic run_txn(input logic [3:0] t, input logic m, input logic [3:0] ej,
                           input logic [3:0] ek, input int attempts, input logic eerr);
        @(negedge clk);
        chk("ready_pre", req_ready, 1);
        req_valid  = 1'b1;
        req_target = t;
        req_mode   = m;
        @(posedge clk);
        follow(ej, ek, attempts, eerr, 1'b1);
        if (!eerr) chk("q_after", q_bank, t);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("err_pulse", err, 0);
        chk("retry_hold", retry_cnt, attempts - 1);
        chk("busy_after", busy, 0);
    endtask

    typedef struct {
        logic [3:0] target;
        logic       mode;
        logic [3:0] ej;
        logic [3:0] ek;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] t, ej, ek, t2, ej2, ek2;
        logic       m;

        vecs[0] = '{4'b1010, 1'b0, 4'b1010, 4'b0000};
        vecs[1] = '{4'b0110, 1'b1, 4'b1100, 4'b1100};
        vecs[2] = '{4'b0110, 1'b0, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0110, 1'b1, 4'b0000, 4'b0000};
        vecs[4] = '{4'b1001, 1'b0, 4'b1001, 4'b0110};
        vecs[5] = '{4'b0000, 1'b1, 4'b1001, 4'b1001};
        vecs[6] = '{4'b1111, 1'b0, 4'b1111, 4'b0000};
        vecs[7] = '{4'b0101, 1'b0, 4'b0000, 4'b1010};

        #1 reset = 1'b0;
        #1 chk_idle("reset0");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].target, vecs[i].mode, vecs[i].ej, vecs[i].ek, 1, 1'b0);
            q_model = vecs[i].target;
        end

        // Stuck feedback: every attempt sees 0000, so the target is never reached.
        force_en  = 1'b1;
        force_val = 4'b0000;
        ref_excite(4'b0001, 4'b0000, 1'b0, ej, ek);
        run_txn(4'b0001, 1'b0, 4'b0001, 4'b0000, MAX_RETRY + 1, 1'b1);
        chk("stuck_model_j", ej, 4'b0001);
        force_en = 1'b0;
        q_model  = q_model | 4'b0001;
        chk("q_after_stuck", q_bank, q_model);

        // Reset mid-cycle during DRIVE.
        @(negedge clk);
        t = ~q_model;
        ref_excite(t, q_model, 1'b0, ej, ek);
        req_valid  = 1'b1;
        req_target = t;
        req_mode   = 1'b0;
        @(posedge clk);
        #1 chk("drive_j_pre_rst", j, ej);
        #1 reset = 1'b0;
        #1 chk_idle("rst_drive");
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("q_after_rst_drive", q_bank, q_model);
        t = $urandom_range(0, 15);
        ref_excite(t, q_model, 1'b1, ej, ek);
        run_txn(t, 1'b1, ej, ek, 1, 1'b0);
        q_model = t;

        // Reset during WAIT: the flip-flops already took the drive.
        @(negedge clk);
        t = ~q_model;
        ref_excite(t, q_model, 1'b1, ej, ek);
        req_valid  = 1'b1;
        req_target = t;
        req_mode   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("drive_j_wait", j, ej);
        chk("drive_k_wait", k, ek);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_idle("rst_wait");
        q_model = t;
        chk("q_after_rst_wait", q_bank, q_model);
        @(negedge clk);
        reset = 1'b1;
        t = 4'b0011;
        ref_excite(t, q_model, 1'b0, ej, ek);
        run_txn(t, 1'b0, ej, ek, 1, 1'b0);
        q_model = t;

        // Request held through busy, then back-to-back acceptance on the done cycle.
        @(negedge clk);
        t  = 4'b1100;
        t2 = 4'b0110;
        ref_excite(t, q_model, 1'b1, ej, ek);
        ref_excite(t2, t, 1'b0, ej2, ek2);
        req_valid  = 1'b1;
        req_target = t;
        req_mode   = 1'b1;
        @(posedge clk);
        #1;
        req_target = t2;
        req_mode   = 1'b0;
        follow(ej, ek, 1, 1'b0, 1'b0);
        chk("held_q", q_bank, t);
        @(posedge clk);
        follow(ej2, ek2, 1, 1'b0, 1'b1);
        chk("b2b_q", q_bank, t2);
        q_model = t2;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done_pulse", done, 0);
        chk("b2b_busy", busy, 0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 30; i++) begin
            t = 4'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            ref_excite(t, q_model, m, ej, ek);
            run_txn(t, m, ej, ek, 1, 1'b0);
            q_model = t;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
- Drives a bank of WIDTH JK flip-flops, acting as the controller end of the J/K interface.
- Accepts a target word over a valid/ready handshake and computes the per-bit J/K excitation from the fed-back Q.
- Applies the excitation for exactly one clock, waits a settle time, then checks Q against the target.
- On mismatch it retries up to MAX_RETRY times. It pulses done on success or err when retries are exhausted.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- SETTLE, 1, cycles to wait after the drive cycle before comparing Q. Legal values are 1 or more.
- MAX_RETRY, 3, extra drive attempts after the first mismatch. Legal values are 0 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_target  input  WIDTH  desired Q word.
- req_mode  input  1  excitation mode: 0 = set/reset, 1 = toggle.
- q_fb  input  WIDTH  Q outputs of the driven flip-flop bank.
- j  output  WIDTH  J drive, registered.
- k  output  WIDTH  K drive, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: Q matched the target.
- err  output  1  one-cycle pulse: retries exhausted.
- retry_cnt  output  $clog2(MAX_RETRY+1), minimum 1  retries used by the last or current transaction.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - j, k, done, err, retry_cnt and busy go to 0; req_ready goes to 1.
  - Takes effect immediately, including mid-transaction.
  - Captured target and mode are discarded.
- States: IDLE, DRIVE, WAIT, CHECK.
- IDLE:
  - j = k = 0 (flip-flops hold); req_ready = 1.
  - Accept occurs on an edge with req_valid=1. It captures target and mode, clears retry_cnt, loads j/k from q_fb at that edge, and moves to DRIVE.
- Excitation, with q = q_fb sampled at the load edge and t = captured target:
  - mode 0: j = t & ~q, k = ~t & q.
  - mode 1: j = k = t ^ q.
  - If t == q, then j = k = 0. The transaction still runs the full sequence; there is no shortcut.
- DRIVE:
  - Lasts exactly 1 cycle. The flip-flops sample j/k at the edge that leaves DRIVE.
  - At that edge j/k are cleared to 0 and the FSM moves to WAIT with the settle counter set to SETTLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0, the FSM moves to CHECK.
  - WAIT lasts SETTLE cycles.
- CHECK (1 cycle), decided at the edge leaving CHECK:
  - If q_fb == t: go to IDLE and set done=1 for one cycle.
  - Else if retry_cnt < MAX_RETRY: increment retry_cnt, reload j/k from the current q_fb, go to DRIVE.
  - Else: go to IDLE and set err=1 for one cycle.
- Latency:
  - With no retry, done rises SETTLE+2 edges after the accept edge (3 edges for SETTLE=1).
  - Each retry adds SETTLE+2 edges.
- done and err:
  - Mutually exclusive, and only ever high in IDLE.
  - req_ready is 1 during the pulse, so back-to-back acceptance is allowed. The pulse still lasts exactly one cycle.
- req_valid while busy=1 is ignored. No queuing; the requester must hold its request until ready.
- retry_cnt holds its final value until the next accept.
- q_fb is only sampled at the accept edge, at CHECK, and at retry reload. Changes at other times have no effect.

Decomposition:
- Package jk_drv_pkg:
  - state enum {IDLE, DRIVE, WAIT, CHECK}.
  - Mode constants MODE_SETRST=0 and MODE_TOGGLE=1.
- Sub-module jk_excite: purely combinational (target, q, mode) -> (j, k) for a WIDTH vector. It is instantiated once and used for both accept and retry loads.
- The FSM, counters and handshake live in jk_excite_driver.

Test Plan (WIDTH=4, SETTLE=1, MAX_RETRY=3, bench instantiates 4 JK flip-flops fed by j/k and returning q_fb):
- Reset: drop reset to 0 mid-cycle during DRIVE -> j=k=0000, busy=0, done=err=0, req_ready=1 immediately, without waiting for a clock edge.
- Set/reset mode: q=0000, target 1010, mode 0 -> j=1010, k=0000 for one cycle; q=1010; done high 3 edges after accept; retry_cnt=0.
- Toggle mode: q=1010, target 0110, mode 1 -> j=k=1100 for one cycle; q=0110; done at +3 edges.
- Target equals Q: q=0110, target 0110 -> j=k=0000 throughout; done still at +3 edges.
- Stuck bit: force q_fb=0000 with target 0001 -> 4 DRIVE cycles, each j=0001; err pulse at +12 edges; retry_cnt=3; done never asserted.
- Handshake: req_valid held during busy -> not accepted. New request on the done cycle -> accepted, and the next transaction completes normally. Reset asserted in WAIT -> clean IDLE, and the following request completes.
